// File: rtl/ppm_seq.sv
`default_nettype none
// ============================================================================
// Module   : ppm_seq
// Purpose  : Sequential radix-4 Booth multiplier. One partial product is
//            folded per clock into a carry-save pair (OUT1, OUT2) through a
//            3:2 compressor. The product is (OUT1 + OUT2) mod 2^(N+M), read
//            as signed when TC=1 and unsigned when TC=0.
// Ports    : clk       - clock, rising edge
//            rst       - synchronous active-high reset
//            A [N-1:0] - multiplicand
//            B [M-1:0] - multiplier
//            TC        - 1: two's-complement operands, 0: unsigned
//            in_valid  - operands valid       in_ready  - can accept operands
//            OUT1/OUT2 - carry-save result    out_valid - result finished
//            out_ready - consumer takes result
// Revision : 1.0 - initial release
// ============================================================================
module ppm_seq #(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     A,
    input  logic [M-1:0]     B,
    input  logic             TC,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N+M-1:0]   OUT1,
    output logic [N+M-1:0]   OUT2,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int c_w    = N + M;
    // ceil((M+1)/2): one extra extension bit keeps an unsigned top bit of 1
    // from being recoded as a negative digit.
    localparam int c_iter = (M + 2) / 2;
    localparam int c_bw   = 2 * c_iter;
    localparam int c_cw   = $clog2(c_iter + 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(c_iter - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_cw-1:0] r_cnt;
    // Multiplicand pre-shifted by 2i, so the partial product needs no
    // barrel shifter.
    logic [c_w-1:0]  r_a_sh;
    // Extended multiplier with b[-1] at bit 0; shifted right by 2 per
    // iteration so the current Booth triplet always sits in bits [2:0].
    logic [c_bw:0]   r_b_sh;
    logic [c_w-1:0]  r_out1;
    logic [c_w-1:0]  r_out2;

    logic [c_w-1:0]  w_a_ext;
    logic [c_bw-1:0] w_b_ext;
    logic [c_w-1:0]  w_mag;
    logic            w_neg;
    logic [c_w-1:0]  w_pp;
    logic [c_w-1:0]  w_sum;
    logic [c_w-1:0]  w_carry;

    assign w_a_ext = {{M{TC & A[N-1]}}, A};
    assign w_b_ext = {{(c_bw - M){TC & B[M-1]}}, B};

    // Booth digit decode on the current triplet
    always_comb begin
        w_mag = '0;
        w_neg = 1'b0;
        case (r_b_sh[2:0])
            3'b001, 3'b010: w_mag = r_a_sh;
            3'b011:         w_mag = r_a_sh << 1;
            3'b100: begin
                w_mag = r_a_sh << 1;
                w_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                w_mag = r_a_sh;
                w_neg = 1'b1;
            end
            default:        w_mag = '0;
        endcase
    end

    assign w_pp    = w_neg ? (~w_mag + c_w'(1)) : w_mag;

    // 3:2 compressor; the carry's MSB falls off, which is exactly mod 2^W
    assign w_sum   = r_out1 ^ r_out2 ^ w_pp;
    assign w_carry = ((r_out1 & r_out2) | (r_out1 & w_pp) | (r_out2 & w_pp)) << 1;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            c_st_idle: begin
                in_ready = ~rst;
                if (in_valid) begin
                    w_state_nxt = c_st_busy;
                end
            end
            c_st_busy: begin
                if (r_cnt == c_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_out1 <= '0;
            r_out2 <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_cnt  <= '0;
                        r_a_sh <= w_a_ext;
                        r_b_sh <= {w_b_ext, 1'b0};
                        r_out1 <= '0;
                        r_out2 <= '0;
                    end
                end
                c_st_busy: begin
                    r_out1 <= w_sum;
                    r_out2 <= w_carry;
                    r_a_sh <= r_a_sh << 2;
                    r_b_sh <= r_b_sh >> 2;
                    r_cnt  <= r_cnt + c_cw'(1);
                end
                default: begin
                    // DONE: hold the result for the consumer
                end
            endcase
        end
    end

    assign OUT1 = r_out1;
    assign OUT2 = r_out2;

endmodule
`default_nettype wire

// File: doc/ppm_seq.md
Name: ppm_seq

Overview:
- Sequential, parametrised successor to the combinational partial-product multiplier (PPM).
- Multiplies A (N bits) by B (M bits) using radix-4 Booth recoding, one partial product per clock.
- Accumulates into a carry-save pair OUT1/OUT2 with a 3:2 compressor; downstream adds OUT1+OUT2 (mod 2^(N+M)) to get the product.
- Adds run-time signed/unsigned mode and valid/ready handshakes on input and output.

Parameters:
- N, 8, width of operand A (N >= 2)
- M, 8, width of operand B (M >= 1)
- Derived W = N+M, accumulator/output width
- Derived ITER = ceil((M+1)/2), Booth iterations per operation

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- A  in  N  multiplicand
- B  in  M  multiplier
- TC  in  1  1 = two's-complement operands, 0 = unsigned
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- OUT1  out  W  carry-save sum vector
- OUT2  out  W  carry-save carry vector
- out_valid  out  1  OUT1/OUT2 hold a finished result
- out_ready  in  1  consumer accepts result

Behaviour:
- Reset (rst high at an edge): state IDLE, OUT1=0, OUT2=0, out_valid=0, iteration counter=0. in_ready=0 while rst is high, otherwise decoded from state. Reset overrides everything, including mid-operation; the in-flight operation is discarded with no output.
- States: IDLE, BUSY, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE, in_valid=1 at an edge:
  - Capture A, B and TC.
  - Extend A to W bits: sign-extend if TC=1, else zero-extend.
  - Extend B to 2*ITER bits the same way, with appended b[-1]=0.
  - Clear OUT1/OUT2 and the counter; go to BUSY.
- BUSY, iteration i = 0..ITER-1, one per edge:
  - Booth digit d from b[2i+1], b[2i], b[2i-1]: 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1.
  - P = (d * A_ext) << 2i, computed exactly mod 2^W; negative digits use the full-width two's complement.
  - OUT1' = OUT1 ^ OUT2 ^ P.
  - OUT2' = ((OUT1&OUT2)|(OUT1&P)|(OUT2&P)) << 1, truncated to W.
  - After iteration ITER-1, go to DONE.
- Latency: operands accepted at edge k; out_valid=1 after edge k+ITER.
- Invariant: (OUT1+OUT2) mod 2^W = A*B, in the interpretation selected by TC.
- DONE: OUT1/OUT2 held stable while out_ready=0. When out_ready=1 at an edge, go to IDLE; OUT1/OUT2 keep their values, out_valid drops.
- Minimum gap between accepts is ITER+2 edges. No overlap or pipelining of operations.
- in_valid is ignored outside IDLE. A/B/TC may change freely after capture.
- Unsigned mode needs the extra extension bit of B (hence M+1 in ITER) so that a top bit of 1 is not read as negative.
- M=1 signed: B is {0,-1}; ITER=1.

Test Plan:
- N=M=4, TC=1, A=-3, B=5 -> out_valid exactly 3 edges after accept; OUT1+OUT2 mod 256 = 8'hF1 (-15); in_ready=0 while BUSY/DONE.
- N=M=4, TC=0, A=15, B=15 -> OUT1+OUT2 = 225 (8'hE1). Same bits with TC=1 (-1 x -1) -> 1.
- N=M=4, TC=1, extremes: -8 x -8 -> 64; -8 x 7 -> -56 (8'hC8); 0 x -8 -> 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> OUT1/OUT2/out_valid stable, in_valid pulses ignored; out_ready=1 -> IDLE next edge, in_ready=1.
- Reset mid-BUSY: assert rst at iteration 1 -> next edge OUT1=OUT2=0, out_valid=0, IDLE; next accepted operation (6 x -2, TC=1) gives -12.
- N=8, M=6 (ITER=4): 1000 random A/B/TC with random out_ready stalls -> every result matches a reference product mod 2^14; latency is always 4.
